// File: rtl/secure_result_fifo.sv
// Result FIFO for the 128-bit processed-data stage: valid/ready in and out,
// slots zeroed on pop, output bus blanked when idle, multi-cycle zeroize scrub.
module secure_result_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              zeroize,
  output logic              scrub_busy,
  output logic [PTR_W:0]    count,
  output logic              drop_err
);

  typedef enum logic {IDLE, SCRUB} state_t;

  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    idx_q, idx_d;
  logic [PTR_W:0]      count_q, count_d;
  logic                drop_err_q, drop_err_d;
  logic                idle, push, pop;

  // NOTE: the storage array is reset along with the control state because a
  // reset must never leave a sensitive word behind in any slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      drop_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      drop_err_q <= drop_err_d;
      mem_q      <= mem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (zeroize) state_d = SCRUB;
      SCRUB: if (idx_q == LAST_IDX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idle       = (state_q == IDLE);
    in_ready   = idle && (count_q < DEPTH_C);
    out_valid  = idle && (count_q != '0);
    out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    scrub_busy = (state_q == SCRUB);
    count      = idle ? count_q : '0;
    drop_err   = drop_err_q;
  end

  // Zeroize takes priority: a push or pop offered alongside it is discarded.
  assign push = in_valid  && in_ready  && !zeroize;
  assign pop  = out_valid && out_ready && !zeroize;

  always_comb begin
    // NOTE: every target gets a default first so no path infers a latch.
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    idx_d      = idx_q;
    count_d    = count_q;
    drop_err_d = drop_err_q | (in_valid & ~in_ready);
    if (state_q == SCRUB) begin
      mem_d[idx_q] = '0;
      idx_d        = idx_q + 1'b1;
    end else if (zeroize) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      idx_d    = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      // Push and pop never target the same slot: that needs count 0 or DEPTH.
      if (pop) begin
        mem_d[rd_ptr_q] = '0;
        rd_ptr_d        = rd_ptr_q + 1'b1;
      end
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

endmodule

// File: doc/secure_result_fifo.md
Name: secure_result_fifo

Overview:
- Downstream consumer of the 128-bit processed-data stage: captures each result word, buffers it in a small FIFO and delivers it to the consumer over a valid/ready handshake.
- Treats every stored word as sensitive:
  - a slot is zeroed on the same edge it is popped;
  - the output bus reads zero whenever no word is presented;
  - a zeroize request wipes all storage with a multi-cycle scrub state machine.

Parameters:
- DATA_W, 128, width of a data word.
- DEPTH, 4, number of FIFO slots; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream word present this cycle.
- in_data  input  DATA_W  upstream word.
- in_ready  output  1  block can accept a word this cycle.
- out_valid  output  1  out_data holds the head word.
- out_data  output  DATA_W  head word; all-zero when out_valid=0.
- out_ready  input  1  consumer accepts the head word.
- zeroize  input  1  one-cycle request to wipe all storage.
- scrub_busy  output  1  scrub in progress.
- count  output  PTR_W+1  number of occupied slots, 0..DEPTH.
- drop_err  output  1  sticky: a word was offered while in_ready=0.

Behaviour:
- Reset (synchronous, active-high), sampled at a clk edge:
  - all slots, pointers and count go to 0; state goes to IDLE; drop_err goes to 0.
  - Outputs after that edge: in_ready=1, out_valid=0, out_data=0, scrub_busy=0, count=0.
  - Reset wins over every other input, including mid-scrub.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (state==IDLE) & (count<DEPTH). No push is allowed into a full FIFO, even when a pop happens in the same cycle.
  - out_valid = (state==IDLE) & (count>0).
- Latency: a word pushed at edge N is visible on out_data with out_valid=1 after edge N, i.e. one cycle, when the FIFO was empty.
- Push writes mem[wr_ptr] and increments wr_ptr, wrapping from DEPTH-1 to 0.
- Pop does two things on that edge:
  - writes mem[rd_ptr] to 0;
  - increments rd_ptr, wrapping from DEPTH-1 to 0.
- Push and pop in the same cycle: both take effect and count is unchanged. When count=1, the new word becomes the head on the next cycle.
- out_data is mem[rd_ptr] when out_valid=1, and 0 otherwise. It never exposes a stale or popped word.
- drop_err is set by in_valid & ~in_ready in any state. It is cleared only by reset.
- State machine IDLE/SCRUB:
  - IDLE -> SCRUB when zeroize=1. Zeroize has priority over any push or pop that cycle; neither is performed. On that edge count, wr_ptr and rd_ptr are cleared and scrub index idx=0.
  - SCRUB: each cycle writes mem[idx]=0 and increments idx. After the cycle that clears slot DEPTH-1, the next state is IDLE. The scrub therefore takes exactly DEPTH cycles.
  - In SCRUB: scrub_busy=1, in_ready=0, out_valid=0, out_data=0, count=0.
  - zeroize asserted while in SCRUB is ignored; the scrub does not restart.
- Boundaries:
  - full (count=DEPTH): in_ready=0.
  - empty: out_valid=0 and out_data=0.
  - pointer wrap is modulo DEPTH.
  - count never exceeds DEPTH or underflows.

Test Plan:
1. Reset, then push 0xA5..A5 with out_ready=0 -> the next cycle shows out_valid=1, out_data=0xA5..A5, count=1; then pulse out_ready -> out_valid=0, out_data=0, and the internal slot 0 reads 0.
2. Push 4 words 1,2,3,4 with out_ready=0 -> count=4, in_ready=0; offer word 5 -> drop_err=1, word 5 absent; drain -> output order 1,2,3,4, then count=0.
3. Wrap-around with simultaneous traffic: keep count at 1..2 while pushing and popping every cycle for 10 words -> words delivered in order, count stable, no drops.
4. Zeroize with 3 words held and push/pop asserted in the same cycle -> neither the push nor the pop happens; scrub_busy=1 for exactly 4 cycles, with in_ready=0 and out_data=0 throughout; all slots are then 0, count=0, back in IDLE.
5. zeroize re-asserted in SCRUB cycle 2 -> the scrub still ends after 4 total cycles.
6. Reset asserted mid-scrub and with count=2 -> after the next edge all outputs are at reset values, all slots are 0, and drop_err is cleared.
